mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the fetch stage and the memory stage of the pipelined core. This replaces the separate imem/dmem pair.
- Sequences each access over a fixed number of memory wait cycles.
- Returns read data to the winning requester and produces stall_F/stall_M for the hazard unit.
- Data accesses have priority. A starvation counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between the
// fetch stage and the memory stage.
package mem_arb_pkg;

    // Wide enough for wait and starvation counts up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_D  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    // dmem_SEL access encodings, shared with the data memory.
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                  input logic [CNT_W-1:0] limit);
        return (value >= limit) ? limit : value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: data first, unless a waiting fetch has
// been passed over STARVE_MAX times in a row.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic             flush_F,
    input  logic [CNT_W-1:0] starve_cnt,
    output grant_t           grant,
    output logic [CNT_W-1:0] starve_next
);

    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

    logic if_ok;
    logic force_if;

    assign if_ok    = if_req & ~flush_F;
    assign force_if = if_ok & (starve_cnt == SMAX);

    // A flushed fetch cannot win, so a starved-but-flushed fetch yields to data.
    always_comb begin
        grant       = GNT_NONE;
        starve_next = starve_cnt;
        if (d_req && !force_if) begin
            grant       = GNT_D;
            starve_next = if_req ? sat_inc(starve_cnt, SMAX) : '0;
        end else if (if_ok) begin
            grant       = GNT_IF;
            starve_next = '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port unified memory between instruction fetch and the
// memory stage; each access takes MEM_LAT cycles (legal range 1..15).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush_F,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_F,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_mode,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_M,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [2:0]        mem_mode,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state;
    state_t            state_next;
    grant_t            grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_next;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic [2:0]        lat_mode;
    logic              fetch_killed;
    logic              last_cycle;
    logic              take_grant;

    assign last_cycle = (wait_cnt == '0);
    assign take_grant = (state == IDLE) && (grant != GNT_NONE);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .flush_F     (flush_F),
        .starve_cnt  (starve_cnt),
        .grant       (grant),
        .starve_next (starve_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // mem_we is decoded from state so an asynchronous reset removes it at once.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant == GNT_D) begin
                    state_next = ACC_D;
                end else if (grant == GNT_IF) begin
                    state_next = ACC_IF;
                end
            end
            ACC_IF: begin
                busy = 1'b1;
                if (last_cycle) begin
                    state_next = IDLE;
                end
            end
            ACC_D: begin
                busy   = 1'b1;
                mem_we = lat_we & last_cycle;
                if (last_cycle) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The winner's request is frozen here so requesters may change their
    // inputs freely while the access is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_mode   <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else if (take_grant) begin
            starve_cnt <= starve_next;
            wait_cnt   <= LAT_LOAD;
            if (grant == GNT_D) begin
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_we    <= d_we;
                lat_mode  <= d_mode;
            end else begin
                lat_addr  <= if_addr;
                lat_wdata <= '0;
                lat_we    <= 1'b0;
                lat_mode  <= MODE_W;
            end
        end else if (state != IDLE && !last_cycle) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // A flush seen in any cycle of a fetch access cancels its result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_killed <= 1'b0;
        end else if (state == IDLE) begin
            fetch_killed <= 1'b0;
        end else if (state == ACC_IF && flush_F) begin
            fetch_killed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata <= '0;
            if_valid <= 1'b0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (last_cycle && state == ACC_IF && !fetch_killed && !flush_F) begin
                if_rdata <= mem_rdata;
                if_valid <= 1'b1;
            end
            if (last_cycle && state == ACC_D) begin
                d_valid <= 1'b1;
                if (!lat_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_mode  = lat_mode;

    assign stall_F = if_req & ~if_valid & ~flush_F;
    assign stall_M = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=2 instance with a small memory
// model and a MEM_LAT=1 instance for back-to-back loads.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    logic        if_req = 1'b0, flush_F = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [2:0]  d_mode = MODE_W;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, stall_F, d_valid, stall_M, mem_we, busy;
    logic [2:0]  mem_mode;

    logic        d_req1 = 1'b0;
    logic [31:0] d_addr1 = '0;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_valid1, stall_F1, d_valid1, stall_M1, mem_we1, busy1;
    logic [2:0]  mem_mode1;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .flush_F(flush_F),
        .if_rdata(if_rdata), .if_valid(if_valid), .stall_F(stall_F),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .stall_M(stall_M),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_mode(mem_mode),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr(32'h0), .flush_F(1'b0),
        .if_rdata(if_rdata1), .if_valid(if_valid1), .stall_F(stall_F1),
        .d_req(d_req1), .d_we(1'b0), .d_mode(MODE_W), .d_addr(d_addr1), .d_wdata(32'h0),
        .d_rdata(d_rdata1), .d_valid(d_valid1), .stall_M(stall_M1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_mode(mem_mode1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Unwritten words hold an address-derived pattern; stores are logged.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h10) ? 32'h00500093 : (32'hC0DE0000 ^ a);
    endfunction

    logic [31:0] st_addr [0:7];
    logic [31:0] st_data [0:7];
    int          st_n = 0;

    always @(posedge clk) begin
        if (mem_we && st_n < 8) begin
            st_addr[st_n] <= mem_addr;
            st_data[st_n] <= mem_wdata;
            st_n          <= st_n + 1;
        end
    end

    function automatic logic [31:0] read_mem(input logic [31:0] a);
        logic [31:0] v;
        v = pat(a);
        for (int i = 0; i < 8; i++) begin
            if (i < st_n && st_addr[i] == a) v = st_data[i];
        end
        return v;
    endfunction

    always_comb mem_rdata = read_mem(mem_addr);
    assign mem_rdata1 = pat(mem_addr1);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One complete transaction on u_dut; req drops in the valid cycle.
    task automatic doTxn(input bit fetch, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int we_cyc, output logic [2:0] we_mode,
                         output logic [31:0] rdata, output logic stall_v);
        @(negedge clk);
        if (fetch) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
            d_mode  = MODE_W;
        end
        lat = 0; we_cyc = 0; we_mode = 3'b111; rdata = 32'hFFFF_FFFF; stall_v = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cyc++;
                we_mode = mem_mode;
            end
            if (fetch ? if_valid : d_valid) begin
                lat     = c;
                rdata   = fetch ? if_rdata : d_rdata;
                stall_v = fetch ? stall_F : stall_M;
                break;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_we;
    } vec_t;

    task automatic applyStimulus(input vec_t v, input int idx);
        int          lat, we_cyc;
        logic [2:0]  we_mode;
        logic [31:0] rdata;
        logic        stall_v;
        doTxn(v.fetch, v.we, v.addr, v.wdata, lat, we_cyc, we_mode, rdata, stall_v);
        checkOutput($sformatf("vec%0d_latency", idx), 32'(lat), 32'(LAT0 + 1));
        checkOutput($sformatf("vec%0d_we_cycles", idx), 32'(we_cyc), 32'(v.exp_we));
        checkOutput($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
        checkOutput($sformatf("vec%0d_stall_in_valid", idx), 32'(stall_v), 32'h0);
        if (v.we) checkOutput($sformatf("vec%0d_mode", idx), 32'(we_mode), 32'(MODE_W));
    endtask

    vec_t vecs [7];

    initial begin
        logic [5:0] exp_order;
        logic       stall_bad, seen, both;
        int         k, last, n0;

        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'h00500093, 0};
        vecs[1] = '{1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h00000000, 1};
        vecs[2] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 0};
        vecs[3] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'hC0DE0044, 0};
        vecs[4] = '{1'b0, 1'b1, 32'h44, 32'h0BADF00D, 32'hC0DE0044, 1};
        vecs[5] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'h0BADF00D, 0};
        vecs[6] = '{1'b1, 1'b0, 32'h24, 32'h0,        32'hC0DE0024, 0};

        #2 reset = 1'b1;
        #1;
        checkOutput("reset_rdata", if_rdata | d_rdata, 32'h0);
        checkOutput("reset_mem_addr_wdata", mem_addr | mem_wdata, 32'h0);
        checkOutput("reset_flags", 32'({mem_mode, if_valid, d_valid, mem_we, busy}), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        // Contention: data wins four times, then the starved fetch is forced.
        exp_order = 6'b010000;
        stall_bad = 1'b0;
        both      = 1'b0;
        k         = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h30;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        for (int c = 1; c <= 60 && k < 6; c++) begin
            @(negedge clk);
            if (if_valid && d_valid) both = 1'b1;
            if (if_valid || d_valid) begin
                checkOutput($sformatf("contention_order%0d", k), 32'(if_valid), 32'(exp_order[k]));
                if (if_valid) checkOutput("contention_if_rdata", if_rdata, 32'hC0DE0030);
                if (k == 0) checkOutput("contention_d_rdata", d_rdata, 32'h0BADF00D);
                k++;
                if (k == 6) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end else if (k <= 4 && stall_F !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        checkOutput("contention_count", 32'(k), 32'd6);
        checkOutput("contention_stall_F_held", 32'(stall_bad), 32'h0);
        checkOutput("contention_no_double_valid", 32'(both), 32'h0);

        // Flush in IDLE blocks the grant; flush during ACC_IF kills the result.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20; flush_F = 1'b1;
        @(negedge clk);
        checkOutput("flush_idle_no_grant", 32'(busy), 32'h0);
        flush_F = 1'b0;
        @(negedge clk);
        checkOutput("flush_acc_busy", 32'(busy), 32'h1);
        flush_F = 1'b1;
        #1 checkOutput("flush_stall_F", 32'(stall_F), 32'h0);
        @(negedge clk);
        flush_F = 1'b0; if_req = 1'b0;
        seen = if_valid;
        @(negedge clk);
        checkOutput("flush_back_idle", 32'(busy), 32'h0);
        seen = seen | if_valid;
        repeat (2) begin
            @(negedge clk);
            seen = seen | if_valid;
        end
        checkOutput("flush_no_if_valid", 32'(seen), 32'h0);
        checkOutput("flush_if_rdata_kept", if_rdata, 32'hC0DE0030);

        // Reset during a store, before its final cycle.
        n0 = st_n;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h48; d_wdata = 32'h12345678;
        @(negedge clk);
        checkOutput("rstmid_busy_before", 32'(busy), 32'h1);
        checkOutput("rstmid_we_before", 32'(mem_we), 32'h0);
        #2 reset = 1'b1;
        d_req = 1'b0; d_we = 1'b0;
        #1;
        checkOutput("rstmid_flags", 32'({mem_mode, if_valid, d_valid, mem_we, busy}), 32'h0);
        checkOutput("rstmid_mem_addr", mem_addr, 32'h0);
        checkOutput("rstmid_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rstmid_rdata", if_rdata | d_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstmid_no_store", 32'(st_n), 32'(n0));
        checkOutput("rstmid_mem_intact", read_mem(32'h48), 32'hC0DE0048);

        // MEM_LAT=1: back-to-back loads two cycles apart.
        k = 0; last = 0;
        @(negedge clk);
        d_req1 = 1'b1; d_addr1 = 32'h50;
        for (int c = 1; c <= 30 && k < 3; c++) begin
            @(negedge clk);
            if (d_valid1) begin
                if (k == 0) checkOutput("lat1_first_latency", 32'(c), 32'(LAT1 + 1));
                else        checkOutput($sformatf("lat1_spacing%0d", k), 32'(c - last), 32'd2);
                checkOutput($sformatf("lat1_rdata%0d", k), d_rdata1, 32'hC0DE0050 + 32'(4 * k));
                checkOutput($sformatf("lat1_flags%0d", k),
                            32'({stall_M1, busy1, mem_we1, if_valid1, stall_F1}), 32'h0);
                if (k == 0) begin
                    checkOutput("lat1_mode", 32'(mem_mode1), 32'(MODE_W));
                    checkOutput("lat1_wdata_if_rdata", mem_wdata1 | if_rdata1, 32'h0);
                end
                k++;
                last    = c;
                d_addr1 = 32'h50 + 32'(4 * k);
                if (k == 3) d_req1 = 1'b0;
            end
        end
        checkOutput("lat1_count", 32'(k), 32'd3);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
